// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: result-source encodings and the data-memory
// handshake state type.
package riscv_pkg;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/hazard_lu.sv
// Load-use hazard detector: a load in EX whose destination feeds a source
// operand of the instruction in decode.
module hazard_lu
    import riscv_pkg::*;
(
    input  logic       RegWriteE,
    input  logic [1:0] ResultSrcE,
    input  logic [4:0] RdE,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    output logic       lu
);

    logic load_e;
    logic rd_used;

    assign load_e  = (ResultSrcE == RESULT_LOAD) && RegWriteE && (RdE != 5'd0);
    assign rd_used = (RdE == Rs1D) || (RdE == Rs2D);
    assign lu      = load_e && rd_used;

endmodule

// File: rtl/pipe_mem_ctrl.sv
// Data-memory handshake controller with pipeline stall/flush generation,
// a transaction timeout and a saturating stall-cycle counter.
module pipe_mem_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWriteE,
    input  logic [1:0]       ResultSrcE,
    input  logic [4:0]       RdE,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic             MemWriteM,
    input  logic [1:0]       ResultSrcM,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    input  logic             dmem_rvalid,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushE,
    output logic             FlushW,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    // The wait counter only needs to reach TIMEOUT-1: the cycle that would
    // bring it to TIMEOUT is the abort cycle itself.
    localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    mem_state_e        state;
    mem_state_e        state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              we_q;
    logic              mem_err_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic is_store;
    logic is_load;
    logic memop;
    logic busy;
    logic complete;
    logic timeout;
    logic mem_stall;
    logic req_c;
    logic we_c;
    logic lu;
    logic stall_fd;
    logic stall_em;
    logic flush_e;
    logic flush_w;

    hazard_lu u_hazard_lu (
        .RegWriteE  (RegWriteE),
        .ResultSrcE (ResultSrcE),
        .RdE        (RdE),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .lu         (lu)
    );

    assign is_store = MemWriteM;
    assign is_load  = !MemWriteM && (ResultSrcM == RESULT_LOAD);
    assign memop    = is_store || is_load;

    always_comb begin
        state_next = state;
        req_c      = 1'b0;
        we_c       = 1'b0;
        busy       = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                req_c = memop;
                we_c  = is_store;
                busy  = memop;
                if (is_store) begin
                    if (dmem_ready) complete = 1'b1;
                    else            state_next = REQ;
                end else if (is_load) begin
                    state_next = dmem_ready ? RESP : REQ;
                end
            end
            REQ: begin
                req_c = 1'b1;
                we_c  = we_q;
                busy  = 1'b1;
                if (dmem_ready && we_q) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout    = 1'b1;
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (dmem_ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                busy = 1'b1;
                if (dmem_rvalid) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout    = 1'b1;
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_stall = busy && !complete;

    // A memory stall freezes E as well, so it overrides the load-use bubble.
    assign stall_fd = reset && (mem_stall || lu);
    assign stall_em = reset && mem_stall;
    assign flush_e  = reset && lu && !mem_stall;
    assign flush_w  = reset && mem_stall;

    assign StallF    = stall_fd;
    assign StallD    = stall_fd;
    assign StallE    = stall_em;
    assign StallM    = stall_em;
    assign FlushE    = flush_e;
    assign FlushW    = flush_w;
    assign dmem_req  = reset && req_c;
    assign dmem_we   = reset && we_c;
    assign mem_err   = reset && mem_err_q;
    assign stall_cnt = reset ? stall_cnt_q : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            we_q        <= 1'b0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state     <= state_next;
            mem_err_q <= timeout;
            if (state == IDLE) begin
                wait_cnt <= '0;
                we_q     <= is_store;
            end else begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (stall_fd && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// Self-checking bench for pipe_mem_ctrl: transaction timelines, load-use
// hazards, timeout abort, mid-transaction reset and counter saturation.
module tb_pipe_mem_ctrl;
    import riscv_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       RegWriteE;
    logic [1:0] ResultSrcE;
    logic [4:0] RdE, Rs1D, Rs2D;
    logic       MemWriteM;
    logic [1:0] ResultSrcM;
    logic       dmem_ready, dmem_rvalid;

    logic        dmem_req, dmem_we, StallF, StallD, StallE, StallM, FlushE, FlushW, mem_err;
    logic [31:0] stall_cnt;
    logic        t_dmem_req, t_dmem_we, t_StallF, t_StallD, t_StallE, t_StallM, t_FlushE, t_FlushW, t_mem_err;
    logic [3:0]  t_stall_cnt;

    logic [7:0] obs, t_obs;
    assign obs   = {StallF, StallD, StallE, StallM, FlushE, FlushW, dmem_req, dmem_we};
    assign t_obs = {t_StallF, t_StallD, t_StallE, t_StallM, t_FlushE, t_FlushW, t_dmem_req, t_dmem_we};

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    pipe_mem_ctrl dut (
        .clk(clk), .reset(reset), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .RdE(RdE),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .FlushE(FlushE),
        .FlushW(FlushW), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    pipe_mem_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut_to (
        .clk(clk), .reset(reset), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .RdE(RdE),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .dmem_req(t_dmem_req), .dmem_we(t_dmem_we), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
        .StallF(t_StallF), .StallD(t_StallD), .StallE(t_StallE), .StallM(t_StallM), .FlushE(t_FlushE),
        .FlushW(t_FlushW), .mem_err(t_mem_err), .stall_cnt(t_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit model_lu(bit rw, logic [1:0] src, logic [4:0] rd, logic [4:0] r1, logic [4:0] r2);
        bit producer_is_load = rw && (src == 2'b01) && (rd != 5'd0);
        bit consumer_reads   = (rd == r1) || (rd == r2);
        return producer_is_load && consumer_reads;
    endfunction

    task automatic drive_idle();
        RegWriteE = 1'b0; ResultSrcE = 2'b00; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
        MemWriteM = 1'b0; ResultSrcM = 2'b00; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        @(negedge clk);
        reset = 1'b1;
        exp_cnt = 0;
    endtask

    // One memory op: ready arrives at cycle d1, a load's rvalid d2 cycles later.
    // Completion lands at cycle c; every earlier cycle is a full stall.
    task automatic run_txn(input bit st, input int d1, input int d2, input bit noise, input string tag);
        int c = st ? d1 : d1 + d2;
        int accepted = 0;
        bit s, rq;
        logic [7:0] exp;
        for (int k = 0; k <= c; k++) begin
            @(negedge clk);
            MemWriteM   = st;
            ResultSrcM  = st ? 2'b00 : 2'b01;
            dmem_ready  = (k == d1) || (noise && !st && k > d1 && ($urandom % 2 == 1));
            dmem_rvalid = (!st && k == d1 + d2) || (noise && k <= d1 && ($urandom % 2 == 1));
            #1;
            s  = (k < c);
            rq = (k <= d1);
            exp = {s, s, s, s, 1'b0, s, rq, st && rq};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: outputs %b required %b", tag, k, obs, exp);
            end
            if (dmem_req && dmem_ready) accepted++;
            if (s) exp_cnt++;
        end
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (accepted !== 1) begin
            errors++;
            $display("FAIL %s accepted: got %0d required 1", tag, accepted);
        end
        checks++;
        if (stall_cnt !== 32'(exp_cnt) || mem_err !== 1'b0 || obs !== 8'h00) begin
            errors++;
            $display("FAIL %s after: stall_cnt %0d req %0d, mem_err %b, outputs %b", tag, stall_cnt, exp_cnt, mem_err, obs);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        MemWriteM = 1'b0; ResultSrcM = 2'b01;
        RegWriteE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
        #1;
        checks++;
        if (obs !== 8'h00 || t_obs !== 8'h00 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%b err %b required all zero", obs, t_obs, mem_err);
        end
        @(negedge clk);
        #1;
        checks++;
        if (stall_cnt !== 32'd0 || dut.state !== IDLE || obs !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: stall_cnt %0d state %0d outputs %b required 0/IDLE/0", stall_cnt, dut.state, obs);
        end
        reset = 1'b1;
        drive_idle();
        exp_cnt = 0;
    endtask

    task automatic test_store_zero_wait();
        do_reset();
        run_txn(1'b1, 0, 0, 1'b0, "store_zero_wait");
        checks++;
        if (dut.state !== IDLE || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL store_zero_wait_state: state %0d stall_cnt %0d required IDLE and 0", dut.state, stall_cnt);
        end
    endtask

    task automatic test_load_wait();
        do_reset();
        run_txn(1'b0, 2, 3, 1'b0, "load_wait");
        checks++;
        if (stall_cnt !== 32'd5) begin
            errors++;
            $display("FAIL load_wait_cnt: stall_cnt %0d required 5", stall_cnt);
        end
        run_txn(1'b1, 3, 0, 1'b0, "store_wait");
    endtask

    task automatic test_load_use();
        logic [7:0] exp;
        bit l;
        do_reset();
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            drive_idle();
            case (i)
                0: begin RegWriteE = 1; ResultSrcE = 2'b01; RdE = 5; Rs1D = 5; Rs2D = 9; end
                1: begin RegWriteE = 1; ResultSrcE = 2'b01; RdE = 0; Rs1D = 0; Rs2D = 0; end
                2: begin RegWriteE = 1; ResultSrcE = 2'b01; RdE = 12; Rs1D = 3; Rs2D = 12; end
                3: begin RegWriteE = 0; ResultSrcE = 2'b01; RdE = 5; Rs1D = 5; Rs2D = 5; end
                default: begin
                    RegWriteE  = 1'($urandom);
                    ResultSrcE = 2'($urandom_range(0, 3));
                    RdE        = 5'($urandom_range(0, 5));
                    Rs1D       = 5'($urandom_range(0, 5));
                    Rs2D       = 5'($urandom_range(0, 5));
                end
            endcase
            #1;
            l = model_lu(RegWriteE, ResultSrcE, RdE, Rs1D, Rs2D);
            exp = {l, l, 1'b0, 1'b0, l, 1'b0, 1'b0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL load_use vec %0d: outputs %b required %b", i, obs, exp);
            end
            if (l) exp_cnt++;
        end
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (stall_cnt !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL load_use_cnt: stall_cnt %0d required %0d", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_lu_with_mem();
        logic [7:0] exp;
        do_reset();
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            RegWriteE = 1; ResultSrcE = 2'b01; RdE = 8; Rs1D = 1; Rs2D = 8;
            MemWriteM = 0; ResultSrcM = 2'b01;
            dmem_ready = (k == 1); dmem_rvalid = (k == 2);
            #1;
            exp = (k < 2) ? {6'b111101, (k <= 1), 1'b0} : 8'b11001000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL lu_with_mem cycle %0d: outputs %b required %b", k, obs, exp);
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL lu_with_mem_cnt: stall_cnt %0d required 3", stall_cnt);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] exp;
        int pulses = 0;
        do_reset();
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            drive_idle();
            if (k <= 4) ResultSrcM = 2'b01;
            #1;
            exp = (k < 4) ? 8'b11110110 : (k == 4) ? 8'b00000010 : 8'b00000000;
            checks++;
            if (t_obs !== exp || t_mem_err !== (k == 5)) begin
                errors++;
                $display("FAIL timeout cycle %0d: outputs %b err %b required %b err %b", k, t_obs, t_mem_err, exp, (k == 5));
            end
            if (t_mem_err) pulses++;
            if (k == 5) begin
                checks++;
                if (dut_to.state !== IDLE) begin
                    errors++;
                    $display("FAIL timeout_state: state %0d required IDLE", dut_to.state);
                end
            end
        end
        checks++;
        if (pulses !== 1 || t_stall_cnt !== 4'd4) begin
            errors++;
            $display("FAIL timeout_summary: pulses %0d stall_cnt %0d required 1 and 4", pulses, t_stall_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        ResultSrcM = 2'b01; dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        #1;
        checks++;
        if (dut.state !== RESP) begin
            errors++;
            $display("FAIL reset_mid_setup: state %0d required RESP", dut.state);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 8'h00 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_low: outputs %b stall_cnt %0d required 0", obs, stall_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        dmem_rvalid = 1'b1;
        #1;
        checks++;
        if (dut.state !== IDLE || obs !== 8'h00 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_after: state %0d outputs %b stall_cnt %0d required IDLE/0/0", dut.state, obs, stall_cnt);
        end
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        checks++;
        if (dut.state !== IDLE || obs !== 8'h00 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_late_rvalid: state %0d outputs %b err %b required IDLE/0/0", dut.state, obs, mem_err);
        end
        exp_cnt = 0;
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            RegWriteE = 1; ResultSrcE = 2'b01; RdE = 3; Rs1D = 3; Rs2D = 0;
            exp_cnt++;
        end
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (t_stall_cnt !== 4'hF || stall_cnt !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL saturate: narrow %0d wide %0d required 15 and %0d", t_stall_cnt, stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int n = 0; n < 25; n++) begin
            bit st = 1'($urandom);
            int d1 = int'($urandom_range(0, 4));
            int d2 = int'($urandom_range(1, 4));
            run_txn(st, d1, d2, 1'b1, "random_txn");
        end
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();
        test_reset();
        test_store_zero_wait();
        test_load_wait();
        test_load_use();
        test_lu_with_mem();
        test_timeout();
        test_reset_mid();
        test_saturate();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
